// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB completer memory slice.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  // Saturating increment for the error/violation counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_slv_ram.sv
// DEPTH x DATA_W register memory: synchronous write, asynchronous read, no reset.
module apb_slv_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: commit on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small register memory, with optional pready wait
// states, pslverr on out-of-range addresses and a saturating error counter.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        err_cnt
);

  localparam int unsigned      AW        = $clog2(DEPTH);
  localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]  DEPTH_A   = (ADDR_W + 1)'(DEPTH);

  apb_state_e        state, state_nxt;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              addr_err_q;
  logic [3:0]        wcnt;
  logic [DATA_W-1:0] ram_rdata;

  logic latch_req, load_rd, mem_we, wcnt_load, wcnt_dec, err_inc;
  logic paddr_err;

  assign paddr_err = ({1'b0, paddr} >= DEPTH_A);
  assign pready    = (state == ACCESS) && (wcnt == 4'd0);
  assign pslverr   = pready && addr_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    load_rd   = 1'b0;
    mem_we    = 1'b0;
    wcnt_load = 1'b0;
    wcnt_dec  = 1'b0;
    err_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt = SETUP;
          latch_req = 1'b1;
        end else if (psel && penable) begin
          err_inc = 1'b1;
        end
      end
      SETUP: begin
        if (psel && penable) begin
          state_nxt = ACCESS;
          wcnt_load = 1'b1;
          load_rd   = !write_q && !addr_err_q;
        end else if (psel) begin
          latch_req = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        // Completion takes priority over psel: once wcnt hits zero the
        // transfer is done regardless of what the requester does.
        if (wcnt == 4'd0) begin
          state_nxt = IDLE;
          mem_we    = write_q && !addr_err_q;
          err_inc   = addr_err_q;
        end else if (psel) begin
          wcnt_dec = 1'b1;
        end else begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, read data register, wait counter and error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      addr_err_q <= 1'b0;
      prdata     <= '0;
      wcnt       <= WAIT_INIT;
      err_cnt    <= '0;
    end else begin
      if (latch_req) begin
        addr_q     <= paddr[AW-1:0];
        wdata_q    <= pwdata;
        write_q    <= pwrite;
        addr_err_q <= paddr_err;
      end
      if (load_rd) prdata <= ram_rdata;
      if (wcnt_load)     wcnt <= WAIT_INIT;
      else if (wcnt_dec) wcnt <= wcnt - 4'd1;
      if (err_inc) err_cnt <= sat_inc(err_cnt);
    end
  end

  apb_slv_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (WAIT_CYCLES 0, 3, 2)
// share one APB bus; psel is routed only to the instance under test.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [1:0] sel;
  logic [2:0] psel_i;

  logic [7:0] prdata_o  [3];
  logic       pready_o  [3];
  logic       pslverr_o [3];
  logic [7:0] err_cnt_o [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign psel_i = psel ? (3'd1 << sel) : 3'd0;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .psel(psel_i[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[0]), .pready(pready_o[0]),
    .pslverr(pslverr_o[0]), .err_cnt(err_cnt_o[0]));

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .psel(psel_i[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[1]), .pready(pready_o[1]),
    .pslverr(pslverr_o[1]), .err_cnt(err_cnt_o[1]));

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .psel(psel_i[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_o[2]), .pready(pready_o[2]),
    .pslverr(pslverr_o[2]), .err_cnt(err_cnt_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete APB transfer; address/data are scrambled during ACCESS to
  // confirm the latched request is what gets used.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd_first, output logic [7:0] rd_last,
                          output logic err, output int waits);
    pwrite = wr; paddr = a; pwdata = d; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    paddr = ~a; pwdata = ~d;
    rd_first = prdata_o[sel];
    waits = 0;
    while (!pready_o[sel] && waits < 40) begin
      waits++;
      tick();
    end
    if (!pready_o[sel]) check("pready_timeout", 32'(pready_o[sel]), 32'd1);
    rd_last = prdata_o[sel];
    err     = pslverr_o[sel];
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [7:0] rf, rl;
  logic       er;
  int         w;

  initial begin
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel = 2'd0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_prdata",  32'(prdata_o[0]),  32'h0);
    check("rst_pready",  32'(pready_o[0]),  32'h0);
    check("rst_pslverr", 32'(pslverr_o[0]), 32'h0);
    check("rst_err_cnt", 32'(err_cnt_o[0]), 32'h0);

    // 1) Reset during ACCESS of a write drops the write
    apb_xfer(1'b1, 8'h10, 8'h55, rf, rl, er, w);
    pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hAA; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    check("t1_in_access_pready", 32'(pready_o[0]), 32'h1);
    rst = 1'b0;
    #1;
    check("t1_rst_pready",  32'(pready_o[0]),  32'h0);
    check("t1_rst_prdata",  32'(prdata_o[0]),  32'h0);
    check("t1_rst_err_cnt", 32'(err_cnt_o[0]), 32'h0);
    psel = 1'b0; penable = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    apb_xfer(1'b0, 8'h10, 8'h00, rf, rl, er, w);
    check("t1_read_prewrite", 32'(rl), 32'h55);

    // 2) Zero-wait write then read
    apb_xfer(1'b1, 8'h05, 8'h3C, rf, rl, er, w);
    check("t2_wr_waits",   32'(w),  32'd0);
    check("t2_wr_pslverr", 32'(er), 32'h0);
    apb_xfer(1'b0, 8'h05, 8'h00, rf, rl, er, w);
    check("t2_rd_waits",   32'(w),  32'd0);
    check("t2_rd_prdata",  32'(rl), 32'h3C);
    check("t2_rd_pslverr", 32'(er), 32'h0);

    // 3) Three wait states on a read
    sel = 2'd1;
    apb_xfer(1'b1, 8'h01, 8'h77, rf, rl, er, w);
    apb_xfer(1'b0, 8'h01, 8'h00, rf, rl, er, w);
    check("t3_waits",        32'(w),  32'd3);
    check("t3_prdata_first", 32'(rf), 32'h77);
    check("t3_prdata_last",  32'(rl), 32'h77);
    check("t3_pslverr",      32'(er), 32'h0);

    // 4) Out-of-range write (0x50 aliases 0x10 in the low address bits)
    sel = 2'd0;
    apb_xfer(1'b1, 8'h50, 8'h11, rf, rl, er, w);
    check("t4_pslverr", 32'(er),           32'h1);
    check("t4_waits",   32'(w),            32'd0);
    check("t4_err_cnt", 32'(err_cnt_o[0]), 32'h1);
    apb_xfer(1'b0, 8'h10, 8'h00, rf, rl, er, w);
    check("t4_keep_10", 32'(rl), 32'h55);
    apb_xfer(1'b0, 8'h05, 8'h00, rf, rl, er, w);
    check("t4_keep_05", 32'(rl), 32'h3C);
    apb_xfer(1'b0, 8'h3F, 8'h00, rf, rl, er, w);
    check("t4_edge_3F_ok", 32'(er), 32'h0);
    apb_xfer(1'b0, 8'h40, 8'h00, rf, rl, er, w);
    check("t4_edge_40_err", 32'(er),           32'h1);
    check("t4_err_cnt2",    32'(err_cnt_o[0]), 32'h2);

    // 5a) psel+penable sampled in IDLE
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hEE;
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    check("t5_viol_err_cnt", 32'(err_cnt_o[0]), 32'h3);
    check("t5_viol_pready",  32'(pready_o[0]),  32'h0);
    apb_xfer(1'b0, 8'h05, 8'h00, rf, rl, er, w);
    check("t5_viol_nowrite", 32'(rl), 32'h3C);

    // 5b) psel dropped while waiting in ACCESS
    sel = 2'd2;
    apb_xfer(1'b1, 8'h02, 8'h99, rf, rl, er, w);
    check("t5_w2_waits", 32'(w), 32'd2);
    pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h44; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    check("t5_abort_pready", 32'(pready_o[2]), 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    check("t5_abort_err_cnt", 32'(err_cnt_o[2]), 32'h1);
    apb_xfer(1'b0, 8'h02, 8'h00, rf, rl, er, w);
    check("t5_abort_nowrite", 32'(rl), 32'h99);

    // 6) Saturation: err_cnt starts at 3 on instance 0
    sel = 2'd0;
    for (int i = 0; i < 260; i++) begin
      apb_xfer(1'b0, 8'h40, 8'h00, rf, rl, er, w);
      if (i == 250) check("t6_err_cnt_254", 32'(err_cnt_o[0]), 32'hFE);
      if (i == 251) check("t6_err_cnt_255", 32'(err_cnt_o[0]), 32'hFF);
    end
    check("t6_err_cnt_sat", 32'(err_cnt_o[0]), 32'hFF);
    check("t6_last_pslverr", 32'(er), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
